// File: rtl/cds_sampler_if.sv
// rtl/cds_sampler_if.sv - result stream bundle between the CDS sampler and the readout path
//
// Signals:
//   result_diff   signed window-2 sum minus window-1 sum, DATA_W+CNT_W+1 bits
//   result_cnt1   samples accumulated in window 1
//   result_cnt2   samples accumulated in window 2
//   result_valid  result held and valid
//   result_ready  consumer accepts the result
// Modports:
//   master  sampler side (drives the result, reads ready)
//   slave   readout side (reads the result, drives ready)

interface cds_sampler_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic [DATA_W+CNT_W:0] result_diff;
    logic [CNT_W-1:0]      result_cnt1;
    logic [CNT_W-1:0]      result_cnt2;
    logic                  result_valid;
    logic                  result_ready;

    modport master (
        output result_diff,
        output result_cnt1,
        output result_cnt2,
        output result_valid,
        input  result_ready
    );

    modport slave (
        input  result_diff,
        input  result_cnt1,
        input  result_cnt2,
        input  result_valid,
        output result_ready
    );
endinterface

// File: rtl/cds_sampler.sv
// rtl/cds_sampler.sv - correlated double sampler: accumulates ADC samples per strobe window, emits sum2 - sum1
//
// Ports:
//   clk          ADC clock, all logic on the rising edge
//   reset        synchronous, active-high
//   cds_clk1     window-1 strobe (level)
//   cds_clk2     window-2 strobe (level)
//   cds_done     one-cycle pulse closing window 2
//   adc_data     ADC sample, unsigned DATA_W bits
//   adc_valid    adc_data valid this cycle
//   err_clear    one-cycle pulse clearing the sticky error flags
//   res          result stream (master side of cds_sampler_if)
//   err_seq      sticky: strobe/done protocol order violated
//   err_overrun  sticky: a result was dropped while the previous one was pending
//   err_sat      sticky: a window sample count saturated

module cds_sampler #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cds_clk1,
    input  logic              cds_clk2,
    input  logic              cds_done,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              err_clear,
    cds_sampler_if.master     res,
    output logic              err_seq,
    output logic              err_overrun,
    output logic              err_sat
);

    localparam int SUM_W = DATA_W + CNT_W;
    localparam int RES_W = SUM_W + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ACC1      = 3'd1;
    localparam logic [2:0] S_GAP       = 3'd2;
    localparam logic [2:0] S_ACC2      = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_EMIT      = 3'd5;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [SUM_W-1:0] sum1;
    logic [SUM_W-1:0] sum2;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;

    logic             seq_err;
    logic             take1;
    logic             take2;
    logic             full1;
    logic             full2;
    logic             sat_hit;
    logic             load;
    logic             overrun;
    logic [SUM_W-1:0] base_sum1;
    logic [CNT_W-1:0] base_cnt1;
    logic [SUM_W-1:0] sample_ext;
    logic [RES_W-1:0] diff;

    // Protocol-order checks. A strobe or done arriving in a state that does
    // not expect it aborts the cycle; the IDLE pass clears the partial sums.
    always_comb begin
        seq_err = 1'b0;
        case (state)
            S_IDLE:      seq_err = cds_clk2 | cds_done;
            S_ACC1:      seq_err = cds_clk2 | cds_done;
            S_GAP:       seq_err = cds_clk1 | cds_done;
            S_ACC2:      seq_err = cds_clk1;
            S_WAIT_DONE: seq_err = cds_clk1;
            S_EMIT:      seq_err = cds_done;
            default:     seq_err = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (cds_clk1) state_next = S_ACC1;
            S_ACC1:      if (!cds_clk1) state_next = S_GAP;
            S_GAP:       if (cds_clk2) state_next = S_ACC2;
            // done together with the falling window-2 strobe skips WAIT_DONE
            S_ACC2: begin
                if (cds_done) begin
                    state_next = S_EMIT;
                end else if (!cds_clk2) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: if (cds_done) state_next = S_EMIT;
            S_EMIT:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
        if (seq_err) begin
            state_next = S_IDLE;
        end
    end

    // Window 1 starts accumulating in the IDLE cycle that first sees the
    // strobe, so its running totals must start from zero there rather than
    // from whatever the previous cycle left behind.
    always_comb begin
        base_sum1 = sum1;
        base_cnt1 = cnt1;
        if (state == S_IDLE) begin
            base_sum1 = '0;
            base_cnt1 = '0;
        end
    end

    assign sample_ext = {{CNT_W{1'b0}}, adc_data};

    // Window 2 likewise samples in the GAP cycle that first sees cds_clk2.
    assign take1 = !seq_err && cds_clk1 && adc_valid &&
                   ((state == S_IDLE) || (state == S_ACC1));
    assign take2 = !seq_err && cds_clk2 && adc_valid &&
                   ((state == S_GAP) || (state == S_ACC2));

    // A full count freezes both count and sum, so the sum can never exceed
    // (2^DATA_W - 1) * (2^CNT_W - 1) and the SUM_W accumulator cannot wrap.
    assign full1   = &base_cnt1;
    assign full2   = &cnt2;
    assign sat_hit = (take1 && full1) || (take2 && full2);

    // One extra bit of headroom makes the difference exact in two's complement.
    assign diff = {1'b0, sum2} - {1'b0, sum1};

    // A pending result may be replaced only when it is being consumed in the
    // same cycle; otherwise the new one is dropped and flagged.
    assign load    = (state == S_EMIT) && !seq_err &&
                     (!res.result_valid || res.result_ready);
    assign overrun = (state == S_EMIT) && !seq_err &&
                     res.result_valid && !res.result_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            sum1             <= '0;
            sum2             <= '0;
            cnt1             <= '0;
            cnt2             <= '0;
            res.result_diff  <= '0;
            res.result_cnt1  <= '0;
            res.result_cnt2  <= '0;
            res.result_valid <= 1'b0;
            err_seq          <= 1'b0;
            err_overrun      <= 1'b0;
            err_sat          <= 1'b0;
        end else begin
            state <= state_next;

            if (state == S_IDLE) begin
                sum1 <= '0;
                cnt1 <= '0;
                sum2 <= '0;
                cnt2 <= '0;
            end
            if (take1 && !full1) begin
                sum1 <= base_sum1 + sample_ext;
                cnt1 <= base_cnt1 + CNT_W'(1);
            end
            if (take2 && !full2) begin
                sum2 <= sum2 + sample_ext;
                cnt2 <= cnt2 + CNT_W'(1);
            end

            if (load) begin
                res.result_diff  <= diff;
                res.result_cnt1  <= cnt1;
                res.result_cnt2  <= cnt2;
                res.result_valid <= 1'b1;
            end else if (res.result_ready) begin
                res.result_valid <= 1'b0;
            end

            // A new event in the clearing cycle keeps its flag set.
            err_seq     <= seq_err | (err_seq     & ~err_clear);
            err_overrun <= overrun | (err_overrun & ~err_clear);
            err_sat     <= sat_hit | (err_sat     & ~err_clear);
        end
    end

endmodule

// File: tb/tb_cds_sampler.sv
// tb/tb_cds_sampler.sv - directed, table-driven self-checking bench for cds_sampler

module tb_cds_sampler;

    logic        clk = 1'b0;
    logic        reset;
    logic        cds_clk1;
    logic        cds_clk2;
    logic        cds_done;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic        err_clear;
    logic        ready;

    logic        err_seq, err_overrun, err_sat;
    logic        s_err_seq, s_err_overrun, s_err_sat;

    int n_cmp = 0;
    int n_bad = 0;

    cds_sampler_if #(.DATA_W(16), .CNT_W(16)) rif ();
    cds_sampler_if #(.DATA_W(16), .CNT_W(4))  sif ();

    assign rif.result_ready = ready;
    assign sif.result_ready = ready;

    cds_sampler #(.DATA_W(16), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cds_clk1   (cds_clk1),
        .cds_clk2   (cds_clk2),
        .cds_done   (cds_done),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .err_clear  (err_clear),
        .res        (rif),
        .err_seq    (err_seq),
        .err_overrun(err_overrun),
        .err_sat    (err_sat)
    );

    cds_sampler #(.DATA_W(16), .CNT_W(4)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .cds_clk1   (cds_clk1),
        .cds_clk2   (cds_clk2),
        .cds_done   (cds_done),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .err_clear  (err_clear),
        .res        (sif),
        .err_seq    (s_err_seq),
        .err_overrun(s_err_overrun),
        .err_sat    (s_err_sat)
    );

    always #25 clk = ~clk;

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int     n1;
        int     d1;
        bit     t1;
        int     n2;
        int     d2;
        bit     t2;
        bit     late;
        longint ediff;
        int     ec1;
        int     ec2;
    } vec_t;

    vec_t tbl[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // n valid samples of value d; with tog the valid cycles alternate with
    // junk-data invalid cycles. n == 0 gives one strobe cycle with no sample.
    task automatic window(input bit second, input int n, input int d, input bit tog);
        int cycles;
        cycles = (n == 0) ? 1 : (tog ? 2 * n - 1 : n);
        for (int i = 0; i < cycles; i++) begin
            cds_clk1  = !second;
            cds_clk2  = second;
            adc_valid = (n != 0) && (!tog || (i % 2 == 0));
            adc_data  = adc_valid ? d[15:0] : 16'h5a5a;
            step();
        end
        cds_clk1  = 1'b0;
        cds_clk2  = 1'b0;
        adc_valid = 1'b0;
    endtask

    // Full CDS cycle; returns after the EMIT cycle, so a loaded result is visible.
    task automatic cds_cycle(input vec_t v);
        window(1'b0, v.n1, v.d1, v.t1);
        if (ready) chk("win1_no_result", rif.result_valid, 0);
        step();
        window(1'b1, v.n2, v.d2, v.t2);
        if (v.late) step();
        cds_done = 1'b1;
        step();
        cds_done = 1'b0;
        if (ready) chk("emit_latency_n", rif.result_valid, 0);
        step();
    endtask

    task automatic check_result(input string tag, input longint ediff, input int ec1, input int ec2);
        chk({tag, "_valid"}, rif.result_valid, 1);
        chk({tag, "_diff"},  longint'($signed(rif.result_diff)), ediff);
        chk({tag, "_cnt1"},  rif.result_cnt1, ec1);
        chk({tag, "_cnt2"},  rif.result_cnt2, ec2);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
    endtask

    vec_t v;

    initial begin
        tbl[0] = '{20,   100, 1'b0, 20,   130, 1'b0, 1'b0,     600, 20, 20};
        tbl[1] = '{10,  1000, 1'b1, 10,     0, 1'b1, 1'b1,  -10000, 10, 10};
        tbl[2] = '{ 5,     7, 1'b0,  3,     2, 1'b1, 1'b0,     -29,  5,  3};
        tbl[3] = '{ 1, 65535, 1'b0,  2, 65535, 1'b0, 1'b1,   65535,  1,  2};
        tbl[4] = '{ 0,     0, 1'b0,  4,    50, 1'b0, 1'b0,     200,  0,  4};
        tbl[5] = '{ 3, 65535, 1'b1,  0,     0, 1'b0, 1'b0, -196605,  3,  0};

        reset     = 1'b1;
        cds_clk1  = 1'b0;
        cds_clk2  = 1'b0;
        cds_done  = 1'b0;
        adc_data  = '0;
        adc_valid = 1'b0;
        err_clear = 1'b0;
        ready     = 1'b1;
        step();
        step();
        chk("rst_valid", rif.result_valid, 0);
        chk("rst_diff",  rif.result_diff, 0);
        chk("rst_cnt1",  rif.result_cnt1, 0);
        chk("rst_cnt2",  rif.result_cnt2, 0);
        chk("rst_errs",  {err_seq, err_overrun, err_sat}, 0);
        reset = 1'b0;
        step();

        // Back-to-back cycles: one idle (EMIT) cycle between done and next clk1.
        for (int i = 0; i < 6; i++) begin
            cds_cycle(tbl[i]);
            check_result($sformatf("vec%0d", i), tbl[i].ediff, tbl[i].ec1, tbl[i].ec2);
        end
        step();
        chk("vec_valid_drop", rif.result_valid, 0);
        chk("vec_no_errs", {err_seq, err_overrun, err_sat}, 0);

        // Backpressure: second result dropped, first held.
        ready = 1'b0;
        v = '{4, 10, 1'b0, 4, 20, 1'b0, 1'b0, 0, 0, 0};
        cds_cycle(v);
        check_result("bp_first", 40, 4, 4);
        v = '{2, 5, 1'b0, 2, 1, 1'b0, 1'b0, 0, 0, 0};
        cds_cycle(v);
        chk("bp_overrun", err_overrun, 1);
        check_result("bp_held", 40, 4, 4);
        pulse_clear();
        chk("bp_overrun_cleared", err_overrun, 0);
        // err_clear held across a new overrun: the new event wins.
        err_clear = 1'b1;
        v = '{1, 3, 1'b0, 1, 3, 1'b0, 1'b0, 0, 0, 0};
        cds_cycle(v);
        err_clear = 1'b0;
        chk("bp_clear_vs_event", err_overrun, 1);
        check_result("bp_held2", 40, 4, 4);
        pulse_clear();
        chk("bp_overrun_cleared2", err_overrun, 0);
        ready = 1'b1;
        step();
        chk("bp_ready_drop", rif.result_valid, 0);

        // Sequence error: clk2 with no clk1, then a stray done.
        cds_clk2 = 1'b1;
        step();
        cds_clk2 = 1'b0;
        step();
        cds_done = 1'b1;
        step();
        cds_done = 1'b0;
        chk("seq_err_set", err_seq, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("seq_no_result", rif.result_valid, 0);
        end
        cds_cycle(tbl[0]);
        check_result("seq_recover", 600, 20, 20);
        chk("seq_err_sticky", err_seq, 1);
        pulse_clear();
        chk("seq_err_cleared", err_seq, 0);

        // clk1 reasserted in GAP is also a sequence error.
        cds_clk1 = 1'b1;
        step();
        step();
        cds_clk1 = 1'b0;
        step();
        cds_clk1 = 1'b1;
        step();
        cds_clk1 = 1'b0;
        chk("gap_clk1_err", err_seq, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gap_no_result", rif.result_valid, 0);
        end

        // Saturation on the CNT_W=4 instance.
        reset = 1'b1;
        step();
        reset = 1'b0;
        v = '{20, 1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 0};
        cds_cycle(v);
        check_result("sat_wide", -20, 20, 0);
        chk("sat_wide_flag", err_sat, 0);
        chk("sat_valid", sif.result_valid, 1);
        chk("sat_diff",  longint'($signed(sif.result_diff)), -15);
        chk("sat_cnt1",  sif.result_cnt1, 15);
        chk("sat_cnt2",  sif.result_cnt2, 0);
        chk("sat_flag",  s_err_sat, 1);

        // Reset in the middle of window 2.
        window(1'b0, 3, 9, 1'b0);
        step();
        cds_clk2  = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 16'd4;
        step();
        step();
        reset     = 1'b1;
        cds_clk2  = 1'b0;
        adc_valid = 1'b0;
        step();
        reset = 1'b0;
        chk("mid_rst_valid", rif.result_valid, 0);
        chk("mid_rst_diff",  rif.result_diff, 0);
        chk("mid_rst_cnt1",  rif.result_cnt1, 0);
        chk("mid_rst_cnt2",  rif.result_cnt2, 0);
        chk("mid_rst_errs",  {err_seq, err_overrun, err_sat}, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_rst_no_result", rif.result_valid, 0);
        end
        cds_cycle(tbl[0]);
        check_result("mid_rst_recover", 600, 20, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
